// File: rtl/cle_sdwr_tx.sv
// Bus-mapped serial transmitter: frames a CPU-written byte (start, 8 data LSB-first, [parity], stop)
// onto o_sdwr. Define CLE_SDWR_PARITY_EN to insert an even-parity bit between data and stop.
module cle_sdwr_tx #(
  parameter int unsigned DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sser,
  input  logic       i_ba13,
  input  logic       i_ba12,
  input  logic [3:0] i_ba,
  input  logic       i_br_w,
  input  logic [7:0] i_bd,
  output logic [7:0] o_bd_q,
  output logic       o_bd_oe,
  output logic       o_sdwr,
  output logic       o_busy
);

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
`ifdef CLE_SDWR_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
`endif
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [3:0] A_TXDATA = 4'd0;
  localparam logic [3:0] A_CTRL   = 4'd1;
  localparam logic [3:0] A_STATUS = 4'd2;

  logic [2:0] r_state;
  logic [7:0] r_divcnt;
  logic [2:0] r_bitcnt;
  logic [7:0] r_txbuf;
  logic       r_sdwr;
  logic       r_inv;
  logic       r_ovr;

  logic       w_sel;
  logic       w_wr;
  logic       w_rd;
  logic       w_wr_tx;
  logic       w_wr_ctrl;
  logic       w_rd_stat;
  logic       w_busy;
  logic [2:0] w_state_nx;
  logic [7:0] w_divcnt_nx;
  logic [2:0] w_bitcnt_nx;
  logic [7:0] w_txbuf_nx;
  logic       w_level_nx;
  logic       w_inv_nx;
  logic       w_ovr_nx;

  assign w_sel     = ~i_sser & ~i_ba13 & i_ba12;
  assign w_wr      = w_sel & ~i_br_w;
  assign w_rd      = w_sel & i_br_w;
  assign w_wr_tx   = w_wr & (i_ba == A_TXDATA);
  assign w_wr_ctrl = w_wr & (i_ba == A_CTRL);
  assign w_rd_stat = w_rd & (i_ba == A_STATUS);
  assign w_busy    = (r_state != S_IDLE);

  // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nx  = r_state;
    w_divcnt_nx = r_divcnt;
    w_bitcnt_nx = r_bitcnt;
    w_txbuf_nx  = r_txbuf;
    if (r_state == S_IDLE) begin
      if (w_wr_tx) begin
        w_state_nx  = S_START;
        w_divcnt_nx = DIV_M1;
        w_txbuf_nx  = i_bd;
      end
    end else if (r_divcnt != 8'd0) begin
      w_divcnt_nx = r_divcnt - 8'd1;
    end else begin
      w_divcnt_nx = DIV_M1;
      case (r_state)
        S_START: begin
          w_state_nx  = S_DATA;
          w_bitcnt_nx = 3'd0;
        end
        S_DATA: begin
          if (r_bitcnt == 3'd7) begin
`ifdef CLE_SDWR_PARITY_EN
            w_state_nx = S_PAR;
`else
            w_state_nx = S_STOP;
`endif
            w_bitcnt_nx = 3'd0;
          end else begin
            w_bitcnt_nx = r_bitcnt + 3'd1;
          end
        end
`ifdef CLE_SDWR_PARITY_EN
        S_PAR: w_state_nx = S_STOP;
`endif
        default: begin
          // End of STOP (or an unreachable encoding): fall back to an idle, cleared counter.
          w_state_nx  = S_IDLE;
          w_divcnt_nx = 8'd0;
        end
      endcase
    end
  end

  // The line is registered from next-state so o_sdwr changes on the same edge as the state.
  always_comb begin
    w_level_nx = 1'b1;
    case (w_state_nx)
      S_START: w_level_nx = 1'b0;
      S_DATA:  w_level_nx = w_txbuf_nx[w_bitcnt_nx];
`ifdef CLE_SDWR_PARITY_EN
      S_PAR:   w_level_nx = ^w_txbuf_nx;
`endif
      default: w_level_nx = 1'b1;
    endcase
  end

  assign w_inv_nx = w_wr_ctrl ? i_bd[0] : r_inv;

  // A dropped write and a status read in one cycle leave ovr set.
  always_comb begin
    w_ovr_nx = r_ovr;
    if (w_wr_tx && w_busy) begin
      w_ovr_nx = 1'b1;
    end else if (w_rd_stat) begin
      w_ovr_nx = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_divcnt <= 8'd0;
      r_bitcnt <= 3'd0;
      r_txbuf  <= 8'd0;
      r_sdwr   <= 1'b1;
      r_inv    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_divcnt <= w_divcnt_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_txbuf  <= w_txbuf_nx;
      r_sdwr   <= w_level_nx ^ w_inv_nx;
      r_inv    <= w_inv_nx;
      r_ovr    <= w_ovr_nx;
    end
  end

  always_comb begin
    o_bd_q = 8'd0;
    if (w_rd_stat) begin
      o_bd_q = {6'b0, r_ovr, w_busy};
    end
  end

  assign o_bd_oe = w_rd;
  assign o_sdwr  = r_sdwr;
  assign o_busy  = w_busy;

endmodule

// File: tb/tb_cle_sdwr_tx.sv
// Self-checking bench for cle_sdwr_tx: decode table plus a per-cycle line scoreboard.
module tb_cle_sdwr_tx;

  localparam int DIV = 4;
`ifdef CLE_SDWR_PARITY_EN
  localparam int FL = 11 * DIV;
`else
  localparam int FL = 10 * DIV;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sser, ba13, ba12, br_w;
  logic [3:0] ba;
  logic [7:0] bd;
  logic [7:0] bd_q;
  logic       bd_oe, sdwr, busy;

  int n_vec = 0;
  int n_err = 0;

  logic m_busy = 1'b0;
  logic m_inv  = 1'b0;
  logic m_ovr  = 1'b0;

  typedef struct packed {
    logic sdwr;
    logic busy;
  } samp_t;
  samp_t q_exp[$];

  typedef struct {
    logic       sser, ba13, ba12, br_w;
    logic [3:0] ba;
    logic [7:0] bd;
    logic       exp_oe;
    logic [7:0] exp_q;
  } vec_t;
  vec_t vt[10];

  cle_sdwr_tx #(.DIV(DIV)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_sser (sser),
    .i_ba13 (ba13),
    .i_ba12 (ba12),
    .i_ba   (ba),
    .i_br_w (br_w),
    .i_bd   (bd),
    .o_bd_q (bd_q),
    .o_bd_oe(bd_oe),
    .o_sdwr (sdwr),
    .o_busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected line samples for one frame, one entry per clock after the accepting edge.
  task automatic push_frame(input logic [7:0] d);
    logic lv[11];
    int   nb;
    samp_t s;
    nb = 0;
    lv[nb] = 1'b0; nb++;
    for (int i = 0; i < 8; i++) begin
      lv[nb] = d[i]; nb++;
    end
`ifdef CLE_SDWR_PARITY_EN
    lv[nb] = ^d; nb++;
`endif
    lv[nb] = 1'b1; nb++;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < DIV; k++) begin
        s.sdwr = lv[b] ^ m_inv;
        s.busy = 1'b1;
        q_exp.push_back(s);
      end
    end
  endtask

  task automatic tick();
    samp_t e;
    @(posedge clk);
    #1;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
    end else begin
      e.sdwr = ~m_inv;
      e.busy = 1'b0;
    end
    check("sdwr", {7'b0, sdwr}, {7'b0, e.sdwr});
    check("busy", {7'b0, busy}, {7'b0, e.busy});
    m_busy = e.busy;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q_exp.size() > 0 && g < 500) begin
      tick();
      g++;
    end
    check("drain_timeout", 8'(q_exp.size()), 8'd0);
  endtask

  task automatic idle_bus();
    sser = 1'b1; ba13 = 1'b0; ba12 = 1'b0; br_w = 1'b1; ba = 4'd0; bd = 8'd0;
  endtask

  // One bus cycle: check the combinational read path, update the model, then clock it in.
  task automatic bus(input logic s, input logic a13, input logic a12, input logic rw,
                     input logic [3:0] a, input logic [7:0] d,
                     input logic exp_oe, input logic [7:0] exp_q);
    logic sel;
    sser = s; ba13 = a13; ba12 = a12; br_w = rw; ba = a; bd = d;
    #1;
    check("bd_oe", {7'b0, bd_oe}, {7'b0, exp_oe});
    if (exp_oe) check("bd_q", bd_q, exp_q);
    sel = ~s & ~a13 & a12;
    if (sel && !rw && a == 4'd0) begin
      if (m_busy) m_ovr = 1'b1;
      else push_frame(d);
    end
    if (sel && !rw && a == 4'd1) m_inv = d[0];
    if (sel && rw && a == 4'd2) m_ovr = 1'b0;
    tick();
    idle_bus();
  endtask

  task automatic wr_tx(input logic [7:0] d);
    bus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, d, 1'b0, 8'd0);
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    bus(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, d, 1'b0, 8'd0);
  endtask

  task automatic rd_status(input logic [7:0] exp);
    bus(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 8'd0, 1'b1, exp);
  endtask

  initial begin
    int cnt;
    int guard;

    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'h55, 1'b0, 8'h00};
    vt[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h55, 1'b0, 8'h00};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h55, 1'b0, 8'h00};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 8'hAA, 1'b0, 8'h00};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'h01, 1'b0, 8'h00};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 8'h00, 1'b1, 8'h00};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 8'h00, 1'b1, 8'h00};
    vt[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 8'h00};
    vt[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 8'h00, 1'b0, 8'h00};
    vt[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 8'h00};

    idle_bus();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_status(8'h00);

    for (int i = 0; i < 10; i++) begin
      bus(vt[i].sser, vt[i].ba13, vt[i].ba12, vt[i].br_w, vt[i].ba, vt[i].bd,
          vt[i].exp_oe, vt[i].exp_q);
    end
    run(2);

    // 0xA5 frame and its busy length
    wr_tx(8'hA5);
    cnt = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 200) begin
      cnt++;
      tick();
      guard++;
    end
    check("busy_len", 8'(cnt), 8'(FL));
    run(2);

    // overrun mid-frame, sticky until read
    wr_tx(8'h3C);
    run(10);
    wr_tx(8'h0F);
    rd_status(8'h03);
    rd_status(8'h01);
    drain();
    run(2);
    rd_status(8'h00);

    // inverted line
    wr_ctrl(8'h01);
    run(3);
    wr_tx(8'hFF);
    drain();
    run(2);
    wr_ctrl(8'h00);
    run(2);

    // reset mid-frame, coinciding with a write that must be ignored
    wr_tx(8'h96);
    run(3);
    wr_tx(8'h11);
    run(8);
    sser = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b0; ba = 4'd0; bd = 8'h77;
    rst = 1'b1;
    q_exp.delete();
    m_ovr = 1'b0;
    m_inv = 1'b0;
    tick();
    rst = 1'b0;
    idle_bus();
    run(2);
    rd_status(8'h00);
    wr_tx(8'h69);
    drain();
    run(2);

    // back-to-back: write in the last STOP cycle drops, one cycle later is accepted
    wr_tx(8'h5A);
    run(FL - 1);
    wr_tx(8'h33);
    wr_tx(8'hC3);
    rd_status(8'h03);
    drain();
    run(3);
    rd_status(8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
